tdt_sba_arb: RTL and testbench

Two-requester arbiter and sequencer in front of the debug system-bus-access (SBA) AXI engine in the tdt debug subsystem. It takes single-beat memory commands from requester 0 (DM sbcs/sbdata register path) and requester 1 (abstract-command memory access). It grants one requester round-robin, and rejects illegal size/alignment combinations locally without any bus cycle. For legal commands it issues exactly one qualified `wr_vld` to the engine, waits for completion, and returns read data and error status to the owner.

---
 rtl/tdt_sba_arb_pkg.sv | 20 ++
 rtl/tdt_sba_legal_chk.sv | 27 ++
 rtl/tdt_sba_arb.sv | 204 ++++++++++++++++++++
 tb/tb_tdt_sba_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdt_sba_arb_pkg.sv
// Shared types and constants for the SBA requester arbiter.
// State and error encodings used by the arbiter and its legality checker.
package tdt_sba_arb_pkg;

    localparam int TDT_DM_SBA_DW = 64;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_CHK   = 3'd1,
        ARB_ISSUE = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_RESP  = 3'd4
    } arb_state_e;

    localparam logic [1:0] SBA_ERR_OK    = 2'd0;
    localparam logic [1:0] SBA_ERR_BUS   = 2'd1;
    localparam logic [1:0] SBA_ERR_SIZE  = 2'd2;
    localparam logic [1:0] SBA_ERR_ALIGN = 2'd3;

endpackage

// File: rtl/tdt_sba_legal_chk.sv
// Combinational size/alignment check for one SBA command.
// Size is tested first; alignment only matters for a legal size.
module tdt_sba_legal_chk
    import tdt_sba_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int SZ_MAX = 3
) (
    input  logic [AW-1:0] i_addr,
    input  logic [2:0]    i_size,
    output logic [1:0]    o_err
);

    logic [AW-1:0] w_mask;

    assign w_mask = ~({AW{1'b1}} << i_size);

    always_comb begin
        o_err = SBA_ERR_OK;
        if (int'(i_size) > SZ_MAX) begin
            o_err = SBA_ERR_SIZE;
        end else if ((i_addr & w_mask) != '0) begin
            o_err = SBA_ERR_ALIGN;
        end
    end

endmodule

// File: rtl/tdt_sba_arb.sv
// Round-robin arbiter and sequencer for two requesters of the SBA engine.
// One command in flight; illegal commands are answered without a bus cycle.
module tdt_sba_arb
    import tdt_sba_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int DW             = TDT_DM_SBA_DW,
    parameter int SZ_MAX         = $clog2(DW/8)
) (
    input  logic                      g_mclk,
    input  logic                      mreset_b,
    input  logic                      axim_clk_en,
    input  logic                      r0_req,
    input  logic                      r0_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] r0_addr,
    input  logic [2:0]                r0_size,
    input  logic [DW-1:0]             r0_wdata,
    output logic                      r0_gnt,
    output logic                      r0_done,
    output logic [DW-1:0]             r0_rdata,
    output logic [1:0]                r0_err,
    input  logic                      r1_req,
    input  logic                      r1_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] r1_addr,
    input  logic [2:0]                r1_size,
    input  logic [DW-1:0]             r1_wdata,
    output logic                      r1_gnt,
    output logic                      r1_done,
    output logic [DW-1:0]             r1_rdata,
    output logic [1:0]                r1_err,
    output logic                      wr_vld,
    output logic                      wr_flg,
    output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    output logic [2:0]                wr_size,
    output logic [DW-1:0]             wr_data,
    input  logic                      axi_wr_ready,
    input  logic [DW-1:0]             rd_data,
    input  logic                      sba_error
);

    arb_state_e r_state;
    arb_state_e w_nxt;

    logic                      r_last;
    logic                      r_own;
    logic                      r_wr;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [2:0]                r_size;
    logic [DW-1:0]             r_wdata;
    logic [1:0]                r_err;
    logic [DW-1:0]             r_rdat;
    logic                      r_wr_vld;
    logic                      r_gnt0;
    logic                      r_gnt1;
    logic                      r_done0;
    logic                      r_done1;
    logic [DW-1:0]             r_rdata0;
    logic [DW-1:0]             r_rdata1;
    logic [1:0]                r_err0;
    logic [1:0]                r_err1;

    logic       w_take;
    logic       w_pick;
    logic [1:0] w_chk_err;

    tdt_sba_legal_chk #(
        .AW     (AXI_ADDR_WIDTH),
        .SZ_MAX (SZ_MAX)
    ) u_chk (
        .i_addr (r_addr),
        .i_size (r_size),
        .o_err  (w_chk_err)
    );

    always_ff @(posedge g_mclk or negedge mreset_b) begin
        if (!mreset_b) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_nxt  = r_state;
        w_take = 1'b0;
        w_pick = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                w_take = r0_req | r1_req;
                w_pick = (r0_req & r1_req) ? ~r_last : r1_req;
                if (w_take) begin
                    w_nxt = ARB_CHK;
                end
            end
            ARB_CHK: begin
                w_nxt = (w_chk_err != SBA_ERR_OK) ? ARB_RESP : ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (r_wr_vld & axim_clk_en) begin
                    w_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (axi_wr_ready & axim_clk_en) begin
                    w_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_nxt = ARB_IDLE;
            end
            default: begin
                w_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_mclk or negedge mreset_b) begin
        if (!mreset_b) begin
            r_last   <= 1'b1;
            r_own    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_wdata  <= '0;
            r_err    <= SBA_ERR_OK;
            r_rdat   <= '0;
            r_wr_vld <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= SBA_ERR_OK;
            r_err1   <= SBA_ERR_OK;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_take) begin
                        r_own   <= w_pick;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                        r_wr    <= w_pick ? r1_wr    : r0_wr;
                        r_addr  <= w_pick ? r1_addr  : r0_addr;
                        r_size  <= w_pick ? r1_size  : r0_size;
                        r_wdata <= w_pick ? r1_wdata : r0_wdata;
                    end
                end
                ARB_CHK: begin
                    r_err  <= w_chk_err;
                    r_rdat <= '0;
                end
                // Raise once, drop on the enable cycle that the engine samples.
                ARB_ISSUE: begin
                    r_wr_vld <= ~(r_wr_vld & axim_clk_en);
                end
                ARB_WAIT: begin
                    if (axi_wr_ready & axim_clk_en) begin
                        if (!r_wr) begin
                            r_rdat <= rd_data;
                        end
                        if (sba_error) begin
                            r_err <= SBA_ERR_BUS;
                        end
                    end
                end
                ARB_RESP: begin
                    r_last <= r_own;
                    if (r_own) begin
                        r_done1  <= 1'b1;
                        r_rdata1 <= r_rdat;
                        r_err1   <= r_err;
                    end else begin
                        r_done0  <= 1'b1;
                        r_rdata0 <= r_rdat;
                        r_err0   <= r_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign r0_gnt   = r_gnt0;
    assign r1_gnt   = r_gnt1;
    assign r0_done  = r_done0;
    assign r1_done  = r_done1;
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;
    assign r0_err   = r_err0;
    assign r1_err   = r_err1;
    assign wr_vld   = r_wr_vld;
    assign wr_flg   = r_wr;
    assign wr_addr  = r_addr;
    assign wr_size  = r_size;
    assign wr_data  = r_wdata;

endmodule

// File: tb/tb_tdt_sba_arb.sv
// Scoreboard bench for tdt_sba_arb with a behavioural SBA engine model.
// Drivers queue expectations; negedge monitors pop and compare.
module tb_tdt_sba_arb;

    logic        g_mclk = 1'b0;
    logic        mreset_b;
    logic        axim_clk_en;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [15:0] r0_addr, r1_addr;
    logic [2:0]  r0_size, r1_size;
    logic [63:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_done, r1_gnt, r1_done;
    logic [63:0] r0_rdata, r1_rdata;
    logic [1:0]  r0_err, r1_err;
    logic        wr_vld, wr_flg;
    logic [15:0] wr_addr;
    logic [2:0]  wr_size;
    logic [63:0] wr_data;
    logic        axi_wr_ready;
    logic [63:0] rd_data;
    logic        sba_error;

    tdt_sba_arb #(.AXI_ADDR_WIDTH(16), .DW(64)) dut (
        .g_mclk(g_mclk), .mreset_b(mreset_b), .axim_clk_en(axim_clk_en),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr),
        .r0_size(r0_size), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr),
        .r1_size(r1_size), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .wr_vld(wr_vld), .wr_flg(wr_flg), .wr_addr(wr_addr),
        .wr_size(wr_size), .wr_data(wr_data),
        .axi_wr_ready(axi_wr_ready), .rd_data(rd_data),
        .sba_error(sba_error)
    );

    always #5 g_mclk = ~g_mclk;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  err;
        bit          chk_rd;
        bit          ill;
        int          gcyc;
    } exp_t;

    typedef struct {
        int          own;
        bit          wr;
        logic [15:0] a;
        logic [2:0]  s;
        logic [63:0] d;
        int          gcyc;
    } cmd_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    cmd_t eng_q[$];
    int   glog[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int en_mode = 0;
    int force_err = -1;
    bit force_rd_en = 0;
    logic [63:0] force_rd = '0;
    bit hold = 0;
    int last_served = 1;

    bit busy = 0;
    bit vld_started = 0;
    int lat = 0;
    logic [63:0] resp_rd;
    bit resp_err;

    always @(posedge g_mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm, input int info);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not allowed here, info %0d (cycle %0d)",
                 nm, info, cyc);
    endtask

    // Reference legality rules for DW = 64 (largest size code 3).
    function automatic logic [1:0] model_err(input logic [15:0] a,
                                             input logic [2:0] s);
        int bytes;
        if (int'(s) > 3) return 2'd2;
        bytes = 1 << s;
        if ((int'(a) % bytes) != 0) return 2'd3;
        return 2'd0;
    endfunction

    task automatic drive(input int n, input bit wr, input logic [15:0] a,
                         input logic [2:0] s, input logic [63:0] d,
                         input bit wait_done);
        bit   got;
        exp_t e;
        cmd_t c;
        logic [1:0] ex;
        @(negedge g_mclk);
        if (n == 0) begin
            r0_wr = wr; r0_addr = a; r0_size = s; r0_wdata = d; r0_req = 1'b1;
        end else begin
            r1_wr = wr; r1_addr = a; r1_size = s; r1_wdata = d; r1_req = 1'b1;
        end
        got = 0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(posedge g_mclk); #1;
            got = (n == 0) ? r0_gnt : r1_gnt;
        end
        if (n == 0) r0_req = 1'b0; else r1_req = 1'b0;
        if (!got) begin
            flag("gnt_timeout", n);
            return;
        end
        ex = model_err(a, s);
        if (ex != 2'd0) begin
            e.rd = '0; e.err = ex; e.chk_rd = 0; e.ill = 1; e.gcyc = cyc;
            if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end else begin
            c.own = n; c.wr = wr; c.a = a; c.s = s; c.d = d; c.gcyc = cyc;
            eng_q.push_back(c);
        end
        if (wait_done) begin
            got = 0;
            for (int k = 0; k < 1000 && !got; k++) begin
                @(posedge g_mclk); #1;
                got = (n == 0) ? r0_done : r1_done;
            end
            if (!got) flag("done_timeout", n);
            else last_served = n;
        end
    endtask

    task automatic check_done(input int n, input logic [63:0] rd,
                              input logic [1:0] er);
        exp_t e;
        if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
            flag(n == 0 ? "r0_unexpected_done" : "r1_unexpected_done", n);
            return;
        end
        e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk(n == 0 ? "r0_err" : "r1_err", 64'(er), 64'(e.err));
        if (e.chk_rd) chk(n == 0 ? "r0_rdata" : "r1_rdata", rd, e.rd);
        if (e.ill) chk("illegal_gnt_to_done", 64'(cyc), 64'(e.gcyc + 2));
    endtask

    always @(negedge g_mclk) begin
        if (mreset_b) begin
            if (r0_gnt) glog.push_back(0);
            if (r1_gnt) glog.push_back(1);
            if (r0_gnt && r1_gnt) flag("dual_gnt", 0);
            if (r0_done) check_done(0, r0_rdata, r0_err);
            if (r1_done) check_done(1, r1_rdata, r1_err);
        end
    end

    // Engine model: accepts wr_vld & enable, answers after a random delay.
    always @(negedge g_mclk) begin
        cmd_t c;
        exp_t e;
        if (!mreset_b) begin
            axi_wr_ready = 1'b0;
            sba_error = 1'b0;
            busy = 0;
            vld_started = 0;
        end else begin
            if (axi_wr_ready && axim_clk_en) begin
                axi_wr_ready = 1'b0;
                sba_error = 1'b0;
                rd_data = {$urandom, $urandom};
                busy = 0;
            end
            case (en_mode)
                0: axim_clk_en = 1'b1;
                1: axim_clk_en = (cyc % 3 == 0);
                default: axim_clk_en = 1'($urandom_range(0, 1));
            endcase
            if (busy && !axi_wr_ready && !hold) begin
                if (lat > 0) lat--;
                else begin
                    axi_wr_ready = 1'b1;
                    rd_data = resp_rd;
                    sba_error = resp_err;
                end
            end
            if (wr_vld) begin
                if (busy) flag("two_in_flight", 0);
                else if (eng_q.size() == 0) flag("unexpected_wr_vld", 0);
                else begin
                    if (!vld_started) begin
                        vld_started = 1;
                        chk("gnt_to_wr_vld", 64'(cyc), 64'(eng_q[0].gcyc + 2));
                    end
                    if (axim_clk_en) begin
                        c = eng_q.pop_front();
                        chk("wr_flg", 64'(wr_flg), 64'(c.wr));
                        chk("wr_addr", 64'(wr_addr), 64'(c.a));
                        chk("wr_size", 64'(wr_size), 64'(c.s));
                        chk("wr_data", wr_data, c.d);
                        resp_rd = force_rd_en ? force_rd : {$urandom, $urandom};
                        resp_err = (force_err >= 0) ? (force_err != 0)
                                                    : ($urandom_range(0, 3) == 0);
                        e.rd = c.wr ? 64'd0 : resp_rd;
                        e.err = resp_err ? 2'd1 : 2'd0;
                        e.chk_rd = 1; e.ill = 0; e.gcyc = c.gcyc;
                        if (c.own == 0) exp_q0.push_back(e);
                        else exp_q1.push_back(e);
                        busy = 1;
                        vld_started = 0;
                        lat = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_r0_gnt", 64'(r0_gnt), 64'd0);
        chk("rst_r1_gnt", 64'(r1_gnt), 64'd0);
        chk("rst_r0_done", 64'(r0_done), 64'd0);
        chk("rst_r1_done", 64'(r1_done), 64'd0);
        chk("rst_wr_vld", 64'(wr_vld), 64'd0);
        chk("rst_r0_rdata", r0_rdata, 64'd0);
        chk("rst_r1_rdata", r1_rdata, 64'd0);
        chk("rst_r0_err", 64'(r0_err), 64'd0);
        chk("rst_r1_err", 64'(r1_err), 64'd0);
        chk("rst_wr_flg", 64'(wr_flg), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_size", 64'(wr_size), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
    endtask

    task automatic rand_cmds(input int n, input int cnt);
        logic [15:0] a;
        logic [2:0]  s;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge g_mclk);
            s = 3'($urandom_range(0, 5));
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1 && int'(s) <= 3)
                a = 16'((int'(a) >> s) << s);
            drive(n, 1'($urandom_range(0, 1)), a, s, {$urandom, $urandom}, 1);
        end
    endtask

    initial begin
        int first;
        bit got;
        mreset_b = 1'b0;
        axim_clk_en = 1'b1;
        r0_req = 0; r0_wr = 0; r0_addr = '0; r0_size = '0; r0_wdata = '0;
        r1_req = 0; r1_wr = 0; r1_addr = '0; r1_size = '0; r1_wdata = '0;
        axi_wr_ready = 0; rd_data = '0; sba_error = 0;
        repeat (3) @(negedge g_mclk);
        chk_reset_outputs();
        mreset_b = 1'b1;
        repeat (2) @(negedge g_mclk);

        force_err = 0;
        drive(0, 1, 16'h0010, 3'd3, 64'h1122334455667788, 1);

        en_mode = 1;
        force_rd_en = 1;
        force_rd = 64'h00000000DEADBEEF;
        drive(1, 0, 16'h0020, 3'd3, 64'd0, 1);
        force_rd_en = 0;
        en_mode = 0;

        drive(0, 0, 16'h0000, 3'd4, 64'd0, 1);
        drive(0, 1, 16'h0006, 3'd2, 64'h55, 1);

        glog.delete();
        first = 1 - last_served;
        fork
            begin
                for (int i = 0; i < 2; i++)
                    drive(0, 1, 16'(16 * i), 3'd3, {$urandom, $urandom}, 1);
            end
            begin
                for (int i = 0; i < 2; i++)
                    drive(1, 0, 16'(8 + 16 * i), 3'd3, 64'd0, 1);
            end
        join
        chk("contention_grants", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk("contention_order", 64'(glog[i]), 64'((first + i) % 2));

        force_err = 1;
        drive(1, 0, 16'h0100, 3'd2, 64'd0, 1);
        force_err = 0;
        drive(1, 0, 16'h0104, 3'd2, 64'd0, 1);
        force_err = -1;

        hold = 1;
        drive(0, 0, 16'h0040, 3'd3, 64'd0, 0);
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge g_mclk); #1;
            got = busy;
        end
        if (!got) flag("engine_accept_timeout", 0);
        @(negedge g_mclk);
        mreset_b = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q0.delete();
        exp_q1.delete();
        eng_q.delete();
        hold = 0;
        last_served = 1;
        repeat (3) @(negedge g_mclk);
        mreset_b = 1'b1;
        glog.delete();
        fork
            drive(0, 1, 16'h0200, 3'd1, 64'h1234, 1);
            drive(1, 1, 16'h0300, 3'd0, 64'h56, 1);
        join
        chk("post_reset_grants", 64'(glog.size()), 64'd2);
        if (glog.size() > 0) chk("post_reset_first", 64'(glog[0]), 64'd0);

        en_mode = 2;
        fork
            rand_cmds(0, 12);
            rand_cmds(1, 12);
        join
        en_mode = 0;
        repeat (10) @(negedge g_mclk);
        chk("drain_r0", 64'(exp_q0.size()), 64'd0);
        chk("drain_r1", 64'(exp_q1.size()), 64'd0);
        chk("drain_eng", 64'(eng_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
